// File: rtl/pwm_controller_n.sv
// Multi-channel PWM generator sharing one prescaled period counter.
// Duty words are double-buffered and reload only at period boundaries.
// Supports edge-aligned and centre-aligned counting.
module pwm_controller_n #(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned PRESC_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       enable,
  input  logic                    mode,
  input  logic [PRESC_W-1:0]      prescale,
  input  logic [CNT_W-1:0]        period,
  input  logic [NUM_CH*CNT_W-1:0] duty,
  output logic [NUM_CH-1:0]       pwm_out,
  output logic                    period_end
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [PRESC_W-1:0]    presc;
  logic [PRESC_W-1:0]    presc_nxt;
  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      cnt_nxt;
  logic                  dir_down;
  logic                  dir_nxt;
  logic                  mode_r;
  logic                  mode_nxt;
  logic [CNT_W-1:0]      dreg     [NUM_CH];
  logic [CNT_W-1:0]      dreg_nxt [NUM_CH];
  logic [NUM_CH-1:0]     pwm_nxt;
  logic                  pend_nxt;
  logic                  tick;
  logic                  load;
  logic                  any_en;

  assign any_en = |enable;

  // Next-state: prescaler, counter/direction, shadow load and compare
  always_comb begin
    state_nxt = state;
    presc_nxt = presc;
    cnt_nxt   = cnt;
    dir_nxt   = dir_down;
    mode_nxt  = mode_r;
    dreg_nxt  = dreg;
    pend_nxt  = 1'b0;
    tick      = 1'b0;
    load      = 1'b0;
    pwm_nxt   = '0;

    case (state)
      ST_IDLE: begin
        // Hold counter at origin and keep shadows tracking the config inputs
        presc_nxt = '0;
        cnt_nxt   = '0;
        dir_nxt   = 1'b0;
        mode_nxt  = mode;
        load      = 1'b1;
        if (any_en) begin
          state_nxt = ST_RUN;
        end
      end

      ST_RUN: begin
        if (!any_en) begin
          state_nxt = ST_IDLE;
          presc_nxt = '0;
          cnt_nxt   = '0;
          dir_nxt   = 1'b0;
          mode_nxt  = mode;
          load      = 1'b1;
        end else begin
          // >= keeps the prescaler from running away if prescale shrinks
          tick      = (presc >= prescale);
          presc_nxt = tick ? '0 : presc + PRESC_W'(1);
          if (tick) begin
            if (!mode_r) begin
              // Edge-aligned: 0..period then wrap
              if (cnt >= period) begin
                cnt_nxt  = '0;
                pend_nxt = 1'b1;
              end else begin
                cnt_nxt = cnt + CNT_W'(1);
              end
              dir_nxt = 1'b0;
            end else if (period == '0) begin
              // Degenerate centre period: stay at zero, every tick ends
              cnt_nxt  = '0;
              dir_nxt  = 1'b0;
              pend_nxt = 1'b1;
            end else if (!dir_down) begin
              if (cnt >= period) begin
                // Turnaround; with period 1 the down step lands on zero at once
                if (cnt == CNT_W'(1)) begin
                  cnt_nxt  = '0;
                  dir_nxt  = 1'b0;
                  pend_nxt = 1'b1;
                end else begin
                  cnt_nxt = cnt - CNT_W'(1);
                  dir_nxt = 1'b1;
                end
              end else begin
                cnt_nxt = cnt + CNT_W'(1);
              end
            end else begin
              if (cnt <= CNT_W'(1)) begin
                cnt_nxt  = '0;
                dir_nxt  = 1'b0;
                pend_nxt = 1'b1;
              end else begin
                cnt_nxt = cnt - CNT_W'(1);
              end
            end
            load = pend_nxt;
          end
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (load) begin
        dreg_nxt[i] = duty[i*CNT_W +: CNT_W];
      end
      pwm_nxt[i] = enable[i] & (cnt_nxt < dreg_nxt[i]);
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      presc      <= '0;
      cnt        <= '0;
      dir_down   <= 1'b0;
      mode_r     <= 1'b0;
      pwm_out    <= '0;
      period_end <= 1'b0;
      for (int i = 0; i < int'(NUM_CH); i++) begin
        dreg[i] <= '0;
      end
    end else begin
      state      <= state_nxt;
      presc      <= presc_nxt;
      cnt        <= cnt_nxt;
      dir_down   <= dir_nxt;
      mode_r     <= mode_nxt;
      pwm_out    <= pwm_nxt;
      period_end <= pend_nxt;
      for (int i = 0; i < int'(NUM_CH); i++) begin
        dreg[i] <= dreg_nxt[i];
      end
    end
  end

endmodule

// File: tb/tb_pwm_controller_n.sv
// Self-checking bench for pwm_controller_n: per-cycle model compare plus
// hand-computed high-time / period_end counts per scenario.
module tb_pwm_controller_n;

  localparam int unsigned NUM_CH  = 4;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned PRESC_W = 8;

  logic                    clk = 1'b0;
  logic                    rst = 1'b0;
  logic [NUM_CH-1:0]       enable = '0;
  logic                    mode = 1'b0;
  logic [PRESC_W-1:0]      prescale = '0;
  logic [CNT_W-1:0]        period = '0;
  logic [NUM_CH*CNT_W-1:0] duty = '0;
  logic [NUM_CH-1:0]       pwm_out;
  logic                    period_end;

  int n_tests = 0;
  int n_fail  = 0;
  int n_print = 0;

  pwm_controller_n #(
    .NUM_CH  (NUM_CH),
    .CNT_W   (CNT_W),
    .PRESC_W (PRESC_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .mode       (mode),
    .prescale   (prescale),
    .period     (period),
    .duty       (duty),
    .pwm_out    (pwm_out),
    .period_end (period_end)
  );

  always #5 clk = ~clk;

  // Model: position within the period waveform; centre-mode count derived
  // from a triangle over 2*period positions.
  bit          m_run  = 1'b0;
  int          m_wait = 0;
  int          m_pos  = 0;
  bit          m_mode = 1'b0;
  int          m_dreg [NUM_CH] = '{default: 0};
  logic [NUM_CH-1:0] exp_pwm = '0;
  logic        exp_pe = 1'b0;

  int meas_hi [NUM_CH];
  int meas_pe;

  task automatic load_duty();
    for (int i = 0; i < int'(NUM_CH); i++) m_dreg[i] = int'(duty[i*CNT_W +: CNT_W]);
  endtask

  task automatic model_step();
    int  p;
    int  c;
    bit  tk;
    bit  pe;
    p  = int'(period);
    tk = 1'b0;
    pe = 1'b0;
    if (enable == '0) begin
      m_run = 1'b0; m_wait = 0; m_pos = 0; m_mode = mode;
      load_duty();
      exp_pwm = '0; exp_pe = 1'b0;
      return;
    end
    if (!m_run) begin
      m_run = 1'b1; m_wait = 0; m_pos = 0; m_mode = mode;
      load_duty();
    end else begin
      m_wait++;
      if (m_wait == int'(prescale) + 1) begin
        tk = 1'b1;
        m_wait = 0;
      end
    end
    if (tk) begin
      if (!m_mode) begin
        if (m_pos >= p) begin m_pos = 0; pe = 1'b1; end
        else m_pos++;
      end else if (p == 0) begin
        m_pos = 0; pe = 1'b1;
      end else begin
        m_pos = (m_pos + 1) % (2 * p);
        pe = (m_pos == 0);
      end
      if (pe) load_duty();
    end
    c = !m_mode ? m_pos : ((m_pos <= p) ? m_pos : 2 * p - m_pos);
    for (int i = 0; i < int'(NUM_CH); i++) exp_pwm[i] = enable[i] && (c < m_dreg[i]);
    exp_pe = pe;
  endtask

  // Model update on every clock edge, reset asynchronously
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_run = 1'b0; m_wait = 0; m_pos = 0; m_mode = 1'b0;
      for (int i = 0; i < int'(NUM_CH); i++) m_dreg[i] = 0;
      exp_pwm = '0; exp_pe = 1'b0;
    end else begin
      model_step();
    end
  end

  // Per-cycle compare of DUT outputs against the model
  initial forever begin
    @(negedge clk);
    n_tests++;
    if (pwm_out !== exp_pwm || period_end !== exp_pe) begin
      n_fail++;
      if (n_print < 20) begin
        n_print++;
        $display("FAIL cycle_cmp t=%0t pwm_out=%b want=%b period_end=%b want=%b",
                 $time, pwm_out, exp_pwm, period_end, exp_pe);
      end
    end
  end

  task automatic check(input string name, input int got, input int want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic measure(input int n);
    for (int i = 0; i < int'(NUM_CH); i++) meas_hi[i] = 0;
    meas_pe = 0;
    repeat (n) begin
      for (int i = 0; i < int'(NUM_CH); i++) if (pwm_out[i] === 1'b1) meas_hi[i]++;
      if (period_end === 1'b1) meas_pe++;
      @(negedge clk);
    end
  endtask

  task automatic check_hi(input string name, input int h0, input int h1,
                          input int h2, input int h3, input int pe);
    check({name, "_ch0"}, meas_hi[0], h0);
    check({name, "_ch1"}, meas_hi[1], h1);
    check({name, "_ch2"}, meas_hi[2], h2);
    check({name, "_ch3"}, meas_hi[3], h3);
    check({name, "_pe"},  meas_pe,    pe);
  endtask

  task automatic summary();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
  endtask

  // Directed scenarios
  initial begin
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_pwm", int'(pwm_out), 0);
    check("reset_pe", int'(period_end), 0);

    // Edge mode basic: period 9, duty {0,3,10,255}
    prescale = 8'd0; period = 8'd9; mode = 1'b0;
    duty = {8'd255, 8'd10, 8'd3, 8'd0};
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle_pwm", int'(pwm_out), 0);
    enable = 4'hF;
    @(negedge clk);
    check("start_pwm", int'(pwm_out), 4'b1110);
    measure(10);
    check_hi("edge_first", 0, 3, 10, 10, 0);
    check("edge_first_end", int'(period_end), 1);
    measure(10);
    check_hi("edge_steady", 0, 3, 10, 10, 1);

    // Double buffering: duty ch1 3->7 at cnt=5
    measure(5);
    check("dbuf_head_ch1", meas_hi[1], 3);
    duty[15:8] = 8'd7;
    measure(5);
    check("dbuf_tail_ch1", meas_hi[1], 0);
    check("dbuf_swap_pe", int'(period_end), 1);
    measure(10);
    check_hi("dbuf_new", 0, 7, 10, 10, 1);

    // Period shrink 9->4 at cnt=8
    repeat (8) @(negedge clk);
    period = 8'd4;
    @(negedge clk);
    check("shrink_wrap_pe", int'(period_end), 1);
    measure(10);
    check("shrink_pe_count", meas_pe, 2);
    check("shrink_ch1", meas_hi[1], 10);

    // Enables: drop ch1 mid-period, then drop all
    repeat (2) @(negedge clk);
    enable = 4'b1101;
    @(negedge clk);
    check("en_drop_ch1", int'(pwm_out), 4'b1100);
    enable = 4'b0000;
    @(negedge clk);
    check("en_all_off", int'(pwm_out), 0);
    measure(20);
    check_hi("idle_quiet", 0, 0, 0, 0, 0);

    // Centre mode: period 3, prescale 1, duty {2,0,3,4}
    mode = 1'b1; period = 8'd3; prescale = 8'd1;
    duty = {8'd4, 8'd3, 8'd0, 8'd2};
    repeat (2) @(negedge clk);
    enable = 4'hF;
    @(negedge clk);
    check("centre_start", int'(pwm_out), 4'b1101);
    measure(12);
    check_hi("centre_first", 6, 0, 10, 12, 0);
    check("centre_first_end", int'(period_end), 1);
    measure(12);
    check_hi("centre_steady", 6, 0, 10, 12, 1);

    // Async reset while outputs are high
    repeat (3) @(negedge clk);
    check("pre_rst_ch3", int'(pwm_out[3]), 1);
    #1 rst = 1'b1;
    #1 check("async_rst_pwm", int'(pwm_out), 0);
    check("async_rst_pe", int'(period_end), 0);
    mode = 1'b0; period = 8'd9; prescale = 8'd0;
    duty = {8'd0, 8'd9, 8'd1, 8'd5};
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    measure(10);
    check_hi("post_rst", 5, 1, 9, 0, 0);
    check("post_rst_end", int'(period_end), 1);

    summary();
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    summary();
    $fatal(1, "watchdog");
  end

endmodule
